// File: rtl/sprite_rom_pkg.sv
// Shared constants and the response tag type for the sprite-ROM scheduler.
package sprite_rom_pkg;

  localparam int NUM_SPRITES     = 2;
  localparam int SPR_ADDR_W      = 15;
  localparam int SPR_DATA_W      = 5;
  localparam int SPR_ROM_DEPTH   = 19200;
  localparam int TRANSPARENT_IDX = 0;

  // Wide enough for the largest supported requester count (8).
  localparam int IDW = 3;

  typedef struct packed {
    logic           vld;
    logic           oor;
    logic [IDW-1:0] id;
  } spr_tag_t;

endpackage

// File: rtl/sprite_rom_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr
// (wrapping modulo N) wins. Outputs a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Round-robin sharing of one synchronous sprite-ROM port between NUM_REQ requesters.
// Optional SPRITE_ROM_RANGE_CHECK_EN: out-of-range addresses skip the ROM and return TRANSPARENT_IDX.
module sprite_rom_scheduler
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ   = NUM_SPRITES,
  parameter int ADDR_W    = SPR_ADDR_W,
  parameter int DATA_W    = SPR_DATA_W,
  parameter int ROM_DEPTH = SPR_ROM_DEPTH,
  parameter int ROM_LAT   = 1,
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IW-1:0]             rsp_id,
  output logic                      busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ROM_LAT < 1 || ROM_LAT > 3 ||
      ROM_DEPTH < 1 || ROM_DEPTH > (1 << ADDR_W)) begin : g_bad_params
    $error("sprite_rom_scheduler: unsupported parameter combination");
  end

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
  logic              gnt_any, gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic [IW-1:0]     rsp_id_q;
  spr_tag_t          tag_d, tag_out;
  spr_tag_t          tag_q [ROM_LAT+1];

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (req_ready),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
  end

`ifdef SPRITE_ROM_RANGE_CHECK_EN
  assign gnt_oor = (32'(gnt_addr) >= ROM_DEPTH);
`else
  assign gnt_oor = 1'b0;
`endif

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = gnt_any & ~gnt_oor;
    tag_d      = '0;
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      rom_addr_d = gnt_addr;
      tag_d.vld  = 1'b1;
      tag_d.oor  = gnt_oor;
      tag_d.id   = IDW'(gnt_idx);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      rsp_data_q <= rsp_data;
      rsp_id_q   <= rsp_id;
      tag_q[0]   <= tag_d;
      for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The last tag stage lines up with rom_q, so the response is formed combinationally.
  assign tag_out = tag_q[ROM_LAT];

  always_comb begin
    rsp_valid = '0;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    if (tag_out.vld) begin
      rsp_valid[IW'(tag_out.id)] = 1'b1;
      rsp_id   = IW'(tag_out.id);
      rsp_data = tag_out.oor ? DATA_W'(TRANSPARENT_IDX) : rom_q;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= ROM_LAT; i++) busy = busy | tag_q[i].vld;
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Directed bench for sprite_rom_scheduler (4 requesters, 2-cycle ROM) with a behavioural ROM.
`timescale 1ns/1ps
module tb_sprite_rom_scheduler;

  localparam int NR    = 4;
  localparam int AW    = 15;
  localparam int DW    = 5;
  localparam int LAT   = 2;
  localparam int DEPTH = 19200;
`ifdef SPRITE_ROM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic          rom_en, busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, rsp_data;
  logic [1:0]    rsp_id;
  logic [AW-1:0] ra [NR];

  always #5 vga_clk = ~vga_clk;

  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

  sprite_rom_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH), .ROM_LAT(LAT)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[4:0] ^ a[9:5] ^ a[14:10];
  endfunction

  // Two-stage synchronous ROM; the first stage holds when not enabled.
  logic [DW-1:0] rq1 = '0, rq2 = '0;
  always @(posedge vga_clk) begin
    if (rom_en) rq1 <= rom_f(rom_addr);
    rq2 <= rq1;
  end
  assign rom_q = rq2;

  // Per-cycle record of what was granted, used to predict later outputs.
  bit            h_vld  [512];
  bit            h_oor  [512];
  logic [1:0]    h_id   [512];
  logic [AW-1:0] h_addr [512];
  int            cyc = 3;
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_rom_addr = '0;
  logic [DW-1:0] exp_rsp_data = '0;
  logic [1:0]    exp_rsp_id   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0] eg);
    int            gi;
    logic [NR-1:0] ev;
    @(posedge vga_clk);
    #1;
    cyc++;
    req_valid = v;
    #3;
    chk("rom_en", rom_en, h_vld[cyc-1] && !h_oor[cyc-1]);
    if (h_vld[cyc-1]) exp_rom_addr = h_addr[cyc-1];
    chk("rom_addr", rom_addr, exp_rom_addr);
    chk("busy", busy, h_vld[cyc-1] || h_vld[cyc-2] || h_vld[cyc-3]);
    ev = '0;
    if (h_vld[cyc-3]) begin
      ev[h_id[cyc-3]] = 1'b1;
      exp_rsp_id      = h_id[cyc-3];
      exp_rsp_data    = h_oor[cyc-3] ? '0 : rom_f(h_addr[cyc-3]);
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data", rsp_data, exp_rsp_data);
    chk("rsp_id", rsp_id, exp_rsp_id);
    chk("req_ready", req_ready, eg);
    gi = 0;
    for (int i = 0; i < NR; i++) if (eg[i]) gi = i;
    h_vld[cyc]  = (eg != '0);
    h_id[cyc]   = 2'(gi);
    h_addr[cyc] = ra[gi];
    h_oor[cyc]  = RC && (ra[gi] >= AW'(DEPTH));
  endtask

  // Asserts reset mid-cycle (possibly with reads in flight) and releases it two edges later.
  task automatic do_reset();
    @(posedge vga_clk);
    #2;
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 512; i++) h_vld[i] = 1'b0;
    exp_rom_addr = '0;
    exp_rsp_data = '0;
    exp_rsp_id   = '0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) ra[i] = '0;

    do_reset();
    repeat (10) cycle(4'b0000, 4'b0000);

    // Single requester granted every cycle.
    ra[0] = 15'h0123;
    repeat (6) cycle(4'b0001, 4'b0001);
    repeat (4) cycle(4'b0000, 4'b0000);

    // Two continuous requesters alternate from requester 0.
    do_reset();
    ra[0] = 15'd100;
    ra[1] = 15'd9700;
    repeat (3) begin
      cycle(4'b0011, 4'b0001);
      cycle(4'b0011, 4'b0010);
    end
    repeat (4) cycle(4'b0000, 4'b0000);

    // Idle requesters skipped; requester 3 drops out mid-stream.
    do_reset();
    ra[0] = 15'd7;
    ra[1] = 15'd5;
    ra[2] = 15'd300;
    ra[3] = 15'd19199;
    repeat (2) begin
      cycle(4'b1010, 4'b0010);
      cycle(4'b1010, 4'b1000);
    end
    repeat (3) cycle(4'b0010, 4'b0010);
    // Pointer sits at 2 after requester 1: full rotation with wrap 3 -> 0.
    cycle(4'b1111, 4'b0100);
    cycle(4'b1111, 4'b1000);
    cycle(4'b1111, 4'b0001);
    cycle(4'b1111, 4'b0010);

    // Two reads in flight when reset hits: no responses afterwards, restart at 0.
    cycle(4'b0011, 4'b0001);
    cycle(4'b0011, 4'b0010);
    do_reset();
    repeat (5) cycle(4'b0000, 4'b0000);
    cycle(4'b0011, 4'b0001);
    cycle(4'b0011, 4'b0010);
    repeat (4) cycle(4'b0000, 4'b0000);

    // Range boundary: 19200 is out of range when checking is built in, 19199 never is.
    ra[2] = 15'd19200;
    cycle(4'b0100, 4'b0100);
    cycle(4'b0000, 4'b0000);
    ra[2] = 15'd19199;
    cycle(4'b0100, 4'b0100);
    repeat (4) cycle(4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
